// File: rtl/eth_mii_rx_framer_pkg.sv
// eth_rx_pkg: shared types and constants for the MII receive framer.
//   rx_state_t  - framer state encoding
//   PRE_NIB/SFD_NIB - preamble and start-of-frame-delimiter nibbles
//   CRC_*       - CRC-32 polynomial, seed and good-frame residue
//   rx_status_t - end-of-frame status bundle
package eth_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP_FRAME,
    DROP,
    EOF
  } rx_state_t;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef struct packed {
    logic [10:0] len;
    logic        mii;
    logic        drib;
    logic        short_f;
    logic        long_f;
    logic        crc;
  } rx_status_t;

endpackage

// File: rtl/eth_mii_rx_framer_if.sv
// eth_mii_rx_framer_if: PHY-side MII receive pins plus the byte stream and
// end-of-frame status produced by the framer.
//   master - framer side (samples MII pins, drives stream/status)
//   slave  - PHY/consumer side (drives MII pins, observes stream/status)
interface eth_mii_rx_framer_if;
  logic [3:0]  MRxD;
  logic        MRxDV;
  logic        MRxErr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic [10:0] rx_len;
  logic        rx_err_mii;
  logic        rx_err_drib;
  logic        rx_err_short;
  logic        rx_err_long;
  logic        rx_err_crc;

  modport master (
    input  MRxD, MRxDV, MRxErr,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_len,
           rx_err_mii, rx_err_drib, rx_err_short, rx_err_long, rx_err_crc
  );

  modport slave (
    output MRxD, MRxDV, MRxErr,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_len,
           rx_err_mii, rx_err_drib, rx_err_short, rx_err_long, rx_err_crc
  );
endinterface

// File: rtl/eth_mii_rx_framer_crc.sv
// eth_crc32_nib: combinational CRC-32 step over one MII nibble.
//   crc      in  32  current CRC register
//   nib      in   4  MII nibble; nib[0] is the first bit on the wire
//   crc_next out 32  register after shifting in the four bits
// The register is kept MSB-first (non-reflected orientation) while the
// wire bits are fed in transmission order, which is arithmetically the
// reflected Ethernet CRC; in this orientation a good frame leaves
// CRC_RESIDUE (0xC704DD7B).
module eth_crc32_nib
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nib,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[31] ^ nib[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                c = {c[30:0], 1'b0};
    end
    crc_next = c;
  end

endmodule

// File: rtl/eth_mii_rx_framer.sv
// eth_mii_rx_framer: MII receive front-end. Strips preamble/SFD, assembles
// nibbles (low first) into bytes and reports one status per frame.
//   MRxClk  in  receive clock, rising edge
//   Reset   in  asynchronous active-high reset
//   rx      eth_mii_rx_framer_if.master: MRxD/MRxDV/MRxErr in,
//           rx_data/rx_valid/rx_sof byte stream out,
//           rx_eof + rx_len/rx_err_* frame status out
// Optional build macro ETH_RX_CRC_CHECK_EN adds the FCS check; without it
// rx_err_crc is tied low and no CRC logic exists.
module eth_mii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int MIN_FRAME   = 64,
  parameter int MAX_FRAME   = 1518,
  parameter int MIN_PRE_NIB = 2
) (
  input  logic                       MRxClk,
  input  logic                       Reset,
  eth_mii_rx_framer_if.master        rx
);

  rx_state_t   state;
  logic [3:0]  pre_cnt;
  logic [3:0]  low_nib;
  logic        phase;
  logic        first;
  logic        err_mii;
  logic        err_long;
  logic [10:0] byte_cnt;
  logic        sfd_hit;
  logic        crc_bad;

  logic [7:0]  byte_p1;
  logic        vld_p1;
  logic        sof_p1;
  logic        eof_p1;
  rx_status_t  status_p1;

  assign sfd_hit = (state == PREAMBLE) && rx.MRxDV && (rx.MRxD == SFD_NIB) &&
                   (pre_cnt >= 4'(MIN_PRE_NIB));

  function automatic rx_status_t make_status(input logic [10:0] cnt,
                                             input logic mii, input logic drib,
                                             input logic lng, input logic crc);
    rx_status_t s;
    s.len     = cnt;
    s.mii     = mii;
    s.drib    = drib;
    s.short_f = (cnt < 11'(MIN_FRAME));
    s.long_f  = lng;
    s.crc     = crc;
    return s;
  endfunction

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc;
  logic [31:0] crc_byte;
  logic [31:0] crc_next;

  eth_crc32_nib u_crc (
    .crc      (crc),
    .nib      (rx.MRxD),
    .crc_next (crc_next)
  );

  // crc_byte is the register as of the last complete byte, so a trailing
  // dribble nibble never enters the check.
  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      crc      <= '0;
      crc_byte <= '0;
    end else if (sfd_hit) begin
      crc      <= CRC_INIT;
      crc_byte <= CRC_INIT;
    end else if (state == DATA && rx.MRxDV) begin
      crc <= crc_next;
      if (phase) crc_byte <= crc_next;
    end
  end

  assign crc_bad = (crc_byte != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // ---- stage p1: framer state and registered outputs ----
  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      state     <= WAIT_IDLE;
      pre_cnt   <= '0;
      low_nib   <= '0;
      phase     <= 1'b0;
      first     <= 1'b0;
      err_mii   <= 1'b0;
      err_long  <= 1'b0;
      byte_cnt  <= '0;
      byte_p1   <= '0;
      vld_p1    <= 1'b0;
      sof_p1    <= 1'b0;
      eof_p1    <= 1'b0;
      status_p1 <= '0;
    end else begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
      eof_p1 <= 1'b0;
      case (state)
        WAIT_IDLE: if (!rx.MRxDV) state <= IDLE;
        IDLE: begin
          if (rx.MRxDV) begin
            if (rx.MRxD == PRE_NIB) begin
              state   <= PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!rx.MRxDV) begin
            state <= IDLE;
          end else if (rx.MRxD == PRE_NIB) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (sfd_hit) begin
            state    <= DATA;
            phase    <= 1'b0;
            byte_cnt <= '0;
            first    <= 1'b1;
            err_mii  <= 1'b0;
            err_long <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!rx.MRxDV) begin
            // A half-received byte is never completed; phase reports it.
            state     <= EOF;
            eof_p1    <= 1'b1;
            status_p1 <= make_status(byte_cnt, err_mii, phase, err_long, crc_bad);
          end else begin
            if (rx.MRxErr) err_mii <= 1'b1;
            if (!phase) begin
              low_nib <= rx.MRxD;
              phase   <= 1'b1;
            end else begin
              phase    <= 1'b0;
              byte_cnt <= byte_cnt + 11'd1;
              if (byte_cnt == 11'(MAX_FRAME)) begin
                err_long <= 1'b1;
                state    <= DROP_FRAME;
              end else begin
                byte_p1 <= {rx.MRxD, low_nib};
                vld_p1  <= 1'b1;
                sof_p1  <= first;
                first   <= 1'b0;
              end
            end
          end
        end
        DROP_FRAME: begin
          if (!rx.MRxDV) begin
            state     <= EOF;
            eof_p1    <= 1'b1;
            status_p1 <= make_status(byte_cnt, err_mii, phase, err_long, crc_bad);
          end else begin
            phase <= ~phase;
            if (phase && byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
          end
        end
        EOF:  state <= IDLE;
        DROP: if (!rx.MRxDV) state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  assign rx.rx_data      = byte_p1;
  assign rx.rx_valid     = vld_p1;
  assign rx.rx_sof       = sof_p1;
  assign rx.rx_eof       = eof_p1;
  assign rx.rx_len       = status_p1.len;
  assign rx.rx_err_mii   = status_p1.mii;
  assign rx.rx_err_drib  = status_p1.drib;
  assign rx.rx_err_short = status_p1.short_f;
  assign rx.rx_err_long  = status_p1.long_f;
  assign rx.rx_err_crc   = status_p1.crc;

endmodule

// File: doc/eth_mii_rx_framer.md
Name: eth_mii_rx_framer

Overview:
- MII receive front-end of the Ethernet MAC, clocked by MRxClk; sits directly on the PHY pins MRxD/MRxDV/MRxErr.
- Strips the preamble and SFD, assembles nibbles into bytes (low nibble first) and streams them to the MAC RX buffer logic.
- Reports one end-of-frame status per frame: byte count, MII error, dribble nibble, length violations and, optionally, CRC result.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_FRAME, 1518, maximum legal frame length in bytes.
- MIN_PRE_NIB, 2, minimum count of 0x5 nibbles before the SFD nibble; the SFD 0x5 nibble is included in this count.

Ports:
- MRxClk  in  1  MII receive clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MRxD  in  4  MII receive nibble.
- MRxDV  in  1  MII receive data valid.
- MRxErr  in  1  MII receive error.
- rx_data  out  8  assembled byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_sof  out  1  high together with rx_valid on the first byte after the SFD.
- rx_eof  out  1  one-cycle pulse; end of frame, status outputs valid.
- rx_len  out  11  frame byte count, saturating at 2047, valid with rx_eof.
- rx_err_mii  out  1  MRxErr was seen during DATA; valid with rx_eof.
- rx_err_drib  out  1  odd nibble count at frame end; valid with rx_eof.
- rx_err_short  out  1  rx_len < MIN_FRAME; valid with rx_eof.
- rx_err_long  out  1  more than MAX_FRAME bytes received; valid with rx_eof.
- rx_err_crc  out  1  CRC residue mismatch; valid with rx_eof.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state WAIT_IDLE; counters and CRC register cleared.
- WAIT_IDLE: stay while MRxDV=1, so a frame already in progress at reset release is never reported. Go to IDLE when MRxDV=0.
- IDLE:
  - MRxDV=1 and MRxD=0x5 -> PREAMBLE, pre_cnt=1.
  - MRxDV=1 and MRxD != 0x5 -> DROP.
- PREAMBLE:
  - MRxD=0x5: pre_cnt++, saturating at 15.
  - MRxD=0xD and pre_cnt >= MIN_PRE_NIB -> DATA; phase=0, byte_cnt=0, CRC=0xFFFFFFFF.
  - Any other nibble, or 0xD too early -> DROP.
  - MRxDV falls -> IDLE. Nothing is reported.
- DATA:
  - phase=0: latch the low nibble.
  - phase=1: rx_data={MRxD, low nibble}; rx_valid pulses in the next cycle (latency of one MRxClk after the high nibble is sampled); byte_cnt++.
  - rx_sof is asserted with the first byte only.
  - MRxErr=1 sets sticky rx_err_mii. The data nibble is still assembled.
  - The byte that would make byte_cnt=MAX_FRAME+1: not emitted; set err_long; go to DROP_FRAME.
  - MRxDV falls -> EOF.
- DROP_FRAME: no rx_valid output. byte_cnt keeps counting, saturating at 2047. MRxDV falls -> EOF.
- EOF (one cycle): rx_eof=1. Status outputs drive final values:
  - rx_len=byte_cnt.
  - drib=phase.
  - short=(byte_cnt<MIN_FRAME).
  - long, mii, crc as accumulated.
  - Then go to IDLE. Status outputs hold until the next EOF.
- DROP (bad preamble): stay while MRxDV=1, then IDLE. No eof is reported.
- Simultaneous events:
  - MRxDV falling on the cycle a byte would complete: no byte is completed; drib=1.
  - MRxErr together with MRxDV=0 is ignored (carrier extension / false carrier).
- Back-to-back frames: MRxDV may reassert on the cycle immediately after EOF. IDLE accepts it in that cycle.
- Reset mid-frame: outputs go to 0 immediately; no eof is issued for the aborted frame.

Optional Feature:
- Macro: ETH_RX_CRC_CHECK_EN.
- Defined:
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per nibble over all DATA nibbles, FCS included.
  - rx_err_crc = (CRC register != residue 0xC704DD7B) at EOF.
  - If rx_err_drib=1, only the complete bytes count toward the check.
- Undefined: no CRC logic is instantiated; rx_err_crc is tied to 0.

Decomposition:
- Package eth_rx_pkg:
  - state enum {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP_FRAME, DROP, EOF}.
  - Constants PRE_NIB=4'h5, SFD_NIB=4'hD, CRC_POLY, CRC_INIT, CRC_RESIDUE.
  - Packed struct rx_status_t {len, mii, drib, short_f, long_f, crc}.
- One sub-module, eth_crc32_nib: combinational next-CRC from current CRC plus one nibble, with registered state inside the framer. Instantiated only under ETH_RX_CRC_CHECK_EN.

Test Plan:
- Good frame: 15x 0x5, 0xD, 64 bytes with correct FCS -> 64 rx_valid pulses, rx_sof on byte 1, rx_eof with rx_len=64 and all error outputs 0.
- Short frame: 40 bytes with valid FCS -> rx_eof with rx_len=40, rx_err_short=1, rx_err_crc=0.
- Oversize frame: 1600 bytes -> exactly 1518 rx_valid pulses, rx_len=1600, rx_err_long=1.
- MRxErr pulse at byte 20 of a 100-byte frame, plus one extra trailing nibble -> rx_err_mii=1, rx_err_drib=1, rx_len=100.
- Bad preamble (0x5, 0x5, 0x3 ...) followed by MRxDV low -> no rx_valid and no rx_eof. The next good frame, started 1 cycle later, is received normally.
- Reset asserted at byte 30 while MRxDV stays high -> outputs 0; no eof for the aborted frame; the remainder is ignored (WAIT_IDLE). A following good frame gives rx_len equal to its true length.
- With ETH_RX_CRC_CHECK_EN defined: corrupt one FCS bit of the 64-byte frame -> rx_err_crc=1.
